// File: rtl/apb_lockstep_master_if.sv
// Request/response handshake plus the shared APB bus towards two lockstep completers.
// Per-completer select/enable/ready/error travel as 2-bit vectors, bit i = completer i.
interface apb_lockstep_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata0;
  logic [DATA_WIDTH-1:0] rsp_rdata1;
  logic [1:0]            rsp_slverr;
  logic [1:0]            rsp_timeout;
  logic                  rsp_mismatch;

  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [1:0]            PSEL;
  logic [1:0]            PENABLE;
  logic [1:0]            PREADY;
  logic [DATA_WIDTH-1:0] PRDATA0;
  logic [DATA_WIDTH-1:0] PRDATA1;
  logic [1:0]            PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  PREADY, PRDATA0, PRDATA1, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata0, rsp_rdata1, rsp_slverr, rsp_timeout, rsp_mismatch,
    output PADDR, PWRITE, PWDATA, PSEL, PENABLE
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output PREADY, PRDATA0, PRDATA1, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata0, rsp_rdata1, rsp_slverr, rsp_timeout, rsp_mismatch,
    input  PADDR, PWRITE, PWDATA, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_lockstep_master.sv
// APB requester broadcasting one transfer at a time to two completers in lockstep and
// returning both results with a mismatch / error / timeout summary. All outputs registered.
module apb_lockstep_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input logic                   PCLK,
  input logic                   PRESET,
  apb_lockstep_master_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;

  localparam logic [31:0] TLAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t state, state_nx;
  logic [1:0]  done, done_nx;
  logic [31:0] tcnt, tcnt_nx;
  logic        accept;
  logic [1:0]  hit, expire;

  logic                  req_ready_nx, rsp_valid_nx, mismatch_nx, pwrite_nx;
  logic [1:0]            psel_nx, penable_nx, slverr_nx, timeout_nx;
  logic [ADDR_WIDTH-1:0] paddr_nx;
  logic [DATA_WIDTH-1:0] pwdata_nx, rdata0_nx, rdata1_nx;

  assign accept = (state == IDLE) && bus.req_valid && bus.req_ready;

  // A real PREADY in the final allowed cycle takes precedence over the forced finish.
  always_comb begin
    hit    = 2'b00;
    expire = 2'b00;
    if (state == ACCESS) begin
      hit = bus.PSEL & bus.PENABLE & bus.PREADY;
      if ((TIMEOUT > 0) && (tcnt == TLAST)) expire = ~done & ~hit;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (&(done | hit | expire)) state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready_nx = 1'b0;
    rsp_valid_nx = 1'b0;
    psel_nx      = 2'b00;
    penable_nx   = 2'b00;
    paddr_nx     = bus.PADDR;
    pwrite_nx    = bus.PWRITE;
    pwdata_nx    = bus.PWDATA;
    rdata0_nx    = bus.rsp_rdata0;
    rdata1_nx    = bus.rsp_rdata1;
    slverr_nx    = bus.rsp_slverr;
    timeout_nx   = bus.rsp_timeout;
    mismatch_nx  = bus.rsp_mismatch;
    done_nx      = done;
    tcnt_nx      = tcnt;
    case (state)
      IDLE: begin
        if (accept) begin
          paddr_nx    = bus.req_addr;
          pwrite_nx   = bus.req_write;
          pwdata_nx   = bus.req_wdata;
          rdata0_nx   = '0;
          rdata1_nx   = '0;
          slverr_nx   = 2'b00;
          timeout_nx  = 2'b00;
          mismatch_nx = 1'b0;
          done_nx     = 2'b00;
          tcnt_nx     = 32'd0;
          psel_nx     = 2'b11;
        end else begin
          req_ready_nx = 1'b1;
        end
      end
      SETUP: begin
        psel_nx    = ~done;
        penable_nx = ~done;
      end
      ACCESS: begin
        tcnt_nx = tcnt + 32'd1;
        done_nx = done | hit | expire;
        if (hit[0]) begin
          rdata0_nx    = bus.PRDATA0;
          slverr_nx[0] = bus.PSLVERR[0];
        end
        if (expire[0]) begin
          rdata0_nx     = '0;
          slverr_nx[0]  = 1'b0;
          timeout_nx[0] = 1'b1;
        end
        if (hit[1]) begin
          rdata1_nx    = bus.PRDATA1;
          slverr_nx[1] = bus.PSLVERR[1];
        end
        if (expire[1]) begin
          rdata1_nx     = '0;
          slverr_nx[1]  = 1'b0;
          timeout_nx[1] = 1'b1;
        end
        // A completer that has finished is released while the other keeps waiting.
        if (&done_nx) begin
          rsp_valid_nx = 1'b1;
          mismatch_nx  = (slverr_nx[0] != slverr_nx[1]) | (|timeout_nx) |
                         (!bus.PWRITE && (rdata0_nx != rdata1_nx));
        end else begin
          psel_nx    = ~done_nx;
          penable_nx = ~done_nx;
        end
      end
      RESP: begin
        if (bus.rsp_ready) req_ready_nx = 1'b1;
        else               rsp_valid_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      done             <= 2'b00;
      tcnt             <= 32'd0;
      bus.req_ready    <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.PSEL         <= 2'b00;
      bus.PENABLE      <= 2'b00;
      bus.PADDR        <= '0;
      bus.PWRITE       <= 1'b0;
      bus.PWDATA       <= '0;
      bus.rsp_rdata0   <= '0;
      bus.rsp_rdata1   <= '0;
      bus.rsp_slverr   <= 2'b00;
      bus.rsp_timeout  <= 2'b00;
      bus.rsp_mismatch <= 1'b0;
    end else begin
      done             <= done_nx;
      tcnt             <= tcnt_nx;
      bus.req_ready    <= req_ready_nx;
      bus.rsp_valid    <= rsp_valid_nx;
      bus.PSEL         <= psel_nx;
      bus.PENABLE      <= penable_nx;
      bus.PADDR        <= paddr_nx;
      bus.PWRITE       <= pwrite_nx;
      bus.PWDATA       <= pwdata_nx;
      bus.rsp_rdata0   <= rdata0_nx;
      bus.rsp_rdata1   <= rdata1_nx;
      bus.rsp_slverr   <= slverr_nx;
      bus.rsp_timeout  <= timeout_nx;
      bus.rsp_mismatch <= mismatch_nx;
    end
  end
endmodule

// File: tb/tb_apb_lockstep_master.sv
// Randomized bench: per transfer, expected bus and response timing follow from the chosen
// wait counts; a negedge compare process checks every output against those expectations.
`timescale 1ns/1ps
module tb_apb_lockstep_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  apb_lockstep_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  apb_lockstep_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  bit          exp_en = 1'b0;
  bit          exp_rsp_chk = 1'b0;
  logic        exp_req_ready, exp_rsp_valid, exp_pwrite, exp_mm;
  logic [1:0]  exp_psel, exp_pen, exp_err, exp_to;
  logic [31:0] exp_addr, exp_wdata, exp_r0, exp_r1;

  int          acc_cyc = 0, rsp_cyc = 0, rv_cnt = 0, pen1_cnt = 0;
  logic        rv_prev = 1'b0;
  logic [31:0] got_r0, got_r1;
  logic [1:0]  got_err, got_to;
  logic        got_mm;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge PCLK) begin
    if (exp_en) begin
      chk("req_ready", 64'(bus.req_ready), 64'(exp_req_ready));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp_valid));
      chk("PSEL",      64'(bus.PSEL),      64'(exp_psel));
      chk("PENABLE",   64'(bus.PENABLE),   64'(exp_pen));
      chk("PADDR",     64'(bus.PADDR),     64'(exp_addr));
      chk("PWRITE",    64'(bus.PWRITE),    64'(exp_pwrite));
      chk("PWDATA",    64'(bus.PWDATA),    64'(exp_wdata));
      if (exp_rsp_chk) begin
        chk("rsp_rdata0",   64'(bus.rsp_rdata0),   64'(exp_r0));
        chk("rsp_rdata1",   64'(bus.rsp_rdata1),   64'(exp_r1));
        chk("rsp_slverr",   64'(bus.rsp_slverr),   64'(exp_err));
        chk("rsp_timeout",  64'(bus.rsp_timeout),  64'(exp_to));
        chk("rsp_mismatch", 64'(bus.rsp_mismatch), 64'(exp_mm));
      end
    end
    if (bus.rsp_valid === 1'b1) begin
      rv_cnt++;
      if (!rv_prev) begin
        rsp_cyc = cyc;
        got_r0  = bus.rsp_rdata0;
        got_r1  = bus.rsp_rdata1;
        got_err = bus.rsp_slverr;
        got_to  = bus.rsp_timeout;
        got_mm  = bus.rsp_mismatch;
      end
    end
    if (bus.PENABLE[1] === 1'b1) pen1_cnt++;
    rv_prev = (bus.rsp_valid === 1'b1);
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic exp_idle();
    exp_en = 1'b1; exp_req_ready = 1'b1; exp_rsp_valid = 1'b0;
    exp_psel = 2'b00; exp_pen = 2'b00; exp_rsp_chk = 1'b0;
  endtask

  task automatic exp_reset();
    exp_en = 1'b1; exp_req_ready = 1'b0; exp_rsp_valid = 1'b0;
    exp_psel = 2'b00; exp_pen = 2'b00; exp_addr = '0; exp_pwrite = 1'b0; exp_wdata = '0;
    exp_rsp_chk = 1'b1; exp_r0 = '0; exp_r1 = '0; exp_err = 2'b00; exp_to = 2'b00; exp_mm = 1'b0;
  endtask

  task automatic junk_apb();
    bus.PREADY  = 2'($urandom);
    bus.PRDATA0 = $urandom;
    bus.PRDATA1 = $urandom;
    bus.PSLVERR = 2'($urandom);
  endtask

  task automatic junk_req();
    bus.req_valid = 1'($urandom);
    bus.req_write = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.rsp_ready = 1'($urandom);
  endtask

  // Completer i answers in ACCESS cycle w_i; w_i >= TO means it never answers.
  task automatic do_xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input int w0, input int w1, input logic [31:0] r0, input logic [31:0] r1,
                         input logic [1:0] er, input int hold, input int gap, input int abort_k);
    int d0, d1, dm;
    bit t0, t1;
    t0 = (w0 >= TO);
    t1 = (w1 >= TO);
    d0 = t0 ? TO - 1 : w0;
    d1 = t1 ? TO - 1 : w1;
    dm = (d0 > d1) ? d0 : d1;
    for (int g = 0; g < gap; g++) begin
      bus.req_valid = 1'b0; bus.rsp_ready = 1'($urandom); junk_apb(); exp_idle(); tick();
    end
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = wd;
    bus.rsp_ready = 1'b0; junk_apb(); exp_idle();
    acc_cyc = cyc; rv_cnt = 0; pen1_cnt = 0;
    tick();
    junk_req(); junk_apb();
    exp_req_ready = 1'b0; exp_psel = 2'b11; exp_pen = 2'b00;
    exp_addr = a; exp_pwrite = wr; exp_wdata = wd;
    for (int k = 0; k <= dm; k++) begin
      tick();
      junk_req(); junk_apb();
      if (!t0 && k == w0) begin
        bus.PREADY[0] = 1'b1; bus.PRDATA0 = r0; bus.PSLVERR[0] = er[0];
      end else if (k <= d0) bus.PREADY[0] = 1'b0;
      if (!t1 && k == w1) begin
        bus.PREADY[1] = 1'b1; bus.PRDATA1 = r1; bus.PSLVERR[1] = er[1];
      end else if (k <= d1) bus.PREADY[1] = 1'b0;
      exp_psel = {(k <= d1), (k <= d0)};
      exp_pen  = exp_psel;
      if (k == abort_k) begin
        PRESET = 1'b1; bus.req_valid = 1'b1;
        tick();
        exp_reset(); PRESET = 1'b0;
        tick();
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0; exp_idle();
        return;
      end
    end
    tick();
    for (int h = 0; h <= hold; h++) begin
      junk_req(); junk_apb();
      bus.rsp_ready = (h == hold);
      exp_psel = 2'b00; exp_pen = 2'b00; exp_rsp_valid = 1'b1; exp_rsp_chk = 1'b1;
      exp_r0  = t0 ? 32'd0 : r0;
      exp_r1  = t1 ? 32'd0 : r1;
      exp_err = {t1 ? 1'b0 : er[1], t0 ? 1'b0 : er[0]};
      exp_to  = {t1, t0};
      exp_mm  = (exp_err[0] != exp_err[1]) || t0 || t1 || (!wr && exp_r0 != exp_r1);
      tick();
    end
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b0; exp_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    int wa, wb, dmx, ak;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0; junk_apb();
    tick();
    exp_reset();
    tick();
    PRESET = 1'b0;
    tick();
    bus.req_valid = 1'b0; exp_idle();

    do_xfer(1'b0, 32'h10, 32'h0, 0, 0, 32'hA5A5_0001, 32'hA5A5_0001, 2'b00, 0, 0, -1);
    chk("t1_latency", 64'(rsp_cyc - acc_cyc), 64'd3);
    chk("t1_rdata0", 64'(got_r0), 64'hA5A5_0001);
    chk("t1_rdata1", 64'(got_r1), 64'hA5A5_0001);
    chk("t1_flags", 64'({got_mm, got_err, got_to}), 64'd0);

    do_xfer(1'b0, 32'h20, 32'h0, 0, 3, 32'h11, 32'h11, 2'b00, 0, 1, -1);
    chk("t2_latency", 64'(rsp_cyc - acc_cyc), 64'd6);
    chk("t2_pen1_cycles", 64'(pen1_cnt), 64'd4);

    do_xfer(1'b0, 32'h30, 32'h0, 1, 0, 32'h1, 32'h2, 2'b00, 0, 0, -1);
    chk("t3_read_mismatch", 64'(got_mm), 64'd1);
    do_xfer(1'b1, 32'h34, 32'hCAFE, 0, 1, 32'h1, 32'h2, 2'b00, 0, 0, -1);
    chk("t3_write_mismatch", 64'(got_mm), 64'd0);

    do_xfer(1'b0, 32'h40, 32'h0, 0, 99, 32'h55, 32'h66, 2'b00, 0, 0, -1);
    chk("t4_timeout", 64'(got_to), 64'b10);
    chk("t4_rdata1", 64'(got_r1), 64'd0);
    chk("t4_mismatch", 64'(got_mm), 64'd1);
    chk("t4_pen1_cycles", 64'(pen1_cnt), 64'd4);

    do_xfer(1'b1, 32'h50, 32'h1234, 0, 0, 32'h0, 32'h0, 2'b01, 5, 0, -1);
    chk("t5_slverr", 64'(got_err), 64'b01);
    chk("t5_mismatch", 64'(got_mm), 64'd1);
    chk("t5_rsp_cycles", 64'(rv_cnt), 64'd6);

    do_xfer(1'b0, 32'h60, 32'h0, 0, 10, 32'h7, 32'h7, 2'b00, 0, 0, 2);
    chk("t6_abort_no_rsp", 64'(rv_cnt), 64'd0);
    do_xfer(1'b0, 32'h64, 32'h0, 0, 0, 32'hBEEF, 32'hBEEF, 2'b00, 0, 0, -1);
    chk("t6_after_latency", 64'(rsp_cyc - acc_cyc), 64'd3);
    chk("t6_after_rdata0", 64'(got_r0), 64'hBEEF);

    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 0) ? ra : $urandom;
      wa = $urandom_range(0, 5);
      wb = $urandom_range(0, 5);
      dmx = ((wa < TO ? wa : TO - 1) > (wb < TO ? wb : TO - 1)) ?
            (wa < TO ? wa : TO - 1) : (wb < TO ? wb : TO - 1);
      ak = ($urandom_range(0, 19) == 0) ? $urandom_range(0, dmx) : -1;
      do_xfer(1'($urandom), $urandom, $urandom, wa, wb, ra, rb,
              ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
              $urandom_range(0, 3), $urandom_range(0, 2), ak);
    end

    exp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
